mult_share_arb: RTL

Round-robin arbiter and sequencer that shares one `mult8x8` sequential multiplier among `NREQ` requesters. It accepts operand pairs from requesters and grants one at a time. For the granted requester it drives the operands and a one-cycle start pulse into the multiplier, waits for `done_flag`, then returns the 16-bit product to that requester. It sits directly in front of the multiplier; everything past it is unchanged.

---
 rtl/mult_share_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin front end sharing one mult8x8 among NREQ users.
// Optional WAIT timeout with error response: define MULT_ARB_TIMEOUT_EN.
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_a,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_dataa,
  input  logic [8*NREQ-1:0] req_datab,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [15:0]       rsp_product,
  output logic              rsp_err,
  output logic              busy,
  output logic              mult_start,
  output logic [7:0]        mult_dataa,
  output logic [7:0]        mult_datab,
  input  logic              mult_done,
  input  logic [15:0]       mult_product
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   rr_idx;
  logic            rr_hit;
  logic [NREQ-1:0] gnt_d;
  logic [NREQ-1:0] rsp_valid_d;
  logic [15:0]     rsp_product_d;
  logic            start_d;
  logic            busy_d;
  logic [7:0]      dataa_d;
  logic [7:0]      datab_d;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW =
    ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d;
  logic          tmo;

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));
`else
  assign rsp_err = 1'b0;
`endif

  // Round-robin pick: first requester at or above ptr, wrapping to 0
  always_comb begin
    int j;
    logic [IW-1:0] jj;
    rr_hit = 1'b0;
    rr_idx = '0;
    j      = 0;
    jj     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j  = (int'(ptr_q) + i) % NREQ;
      jj = IW'(j);
      if (req[jj]) begin
        rr_hit = 1'b1;
        rr_idx = jj;
      end
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    rsp_product_d = '0;
    start_d       = 1'b0;
    dataa_d       = mult_dataa;
    datab_d       = mult_datab;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rr_hit) begin
          state_d = ISSUE;
          win_d   = rr_idx;
          ptr_d   = (rr_idx == IW'(NREQ - 1)) ?
                    '0 : rr_idx + IW'(1);
          gnt_d   = NREQ'(1) << rr_idx;
          start_d = 1'b1;
          dataa_d = req_dataa[8*rr_idx +: 8];
          datab_d = req_datab[8*rr_idx +: 8];
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (mult_done) begin
          state_d       = RESP;
          rsp_valid_d   = NREQ'(1) << win_q;
          rsp_product_d = mult_product;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (tmo) begin
          state_d     = RESP;
          rsp_valid_d = NREQ'(1) << win_q;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      busy        <= 1'b0;
      mult_start  <= 1'b0;
      mult_dataa  <= '0;
      mult_datab  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt         <= gnt_d;
      rsp_valid   <= rsp_valid_d;
      rsp_product <= rsp_product_d;
      busy        <= busy_d;
      mult_start  <= start_d;
      mult_dataa  <= dataa_d;
      mult_datab  <= datab_d;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err     <= err_d;
`endif
    end
  end

endmodule
